// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Purpose  : Bundles the systolic-array write-back lanes, the SRAM write port
//            and the arbiter status lines into one interface.
// Ports    : master - arbiter view (drives SRAM write and status lines)
//            slave  - environment view (drives lanes, sram_ready, clear)
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
  parameter int SA_NUM          = 3,
  parameter int SA_OUTPUT_WIDTH = 12,
  parameter int SRAM_ADDR_SIZE  = 10
);
  // Producer side: one entry per lane
  logic [SA_NUM-1:0][3:0]                 pool_rd_en_out;
  logic [SA_NUM-1:0][SA_OUTPUT_WIDTH-1:0] pool_out;
  logic [SA_NUM-1:0][SRAM_ADDR_SIZE-1:0]  fifo_wr_addr;
  // SRAM write port
  logic                                   sram_ready;
  logic                                   sram_wen;
  logic [SRAM_ADDR_SIZE-1:0]              sram_waddr;
  logic [SA_OUTPUT_WIDTH-1:0]             sram_wdata;
  // Control / status
  logic                                   clear_overflow;
  logic [SA_NUM-1:0]                      lane_full;
  logic [SA_NUM-1:0]                      overflow;
  logic                                   idle;

  modport master (
    input  pool_rd_en_out, pool_out, fifo_wr_addr, sram_ready, clear_overflow,
    output sram_wen, sram_waddr, sram_wdata, lane_full, overflow, idle
  );

  modport slave (
    output pool_rd_en_out, pool_out, fifo_wr_addr, sram_ready, clear_overflow,
    input  sram_wen, sram_waddr, sram_wdata, lane_full, overflow, idle
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Collects write-backs from SA_NUM lanes into per-lane FIFOs and
//            drains them round-robin into a single registered SRAM write port.
// Ports    : clk    - clock, rising edge
//            resetn - asynchronous active-low reset
//            bus    - wb_arbiter_if.master: lane inputs, SRAM write port,
//                     clear_overflow, lane_full, overflow, idle
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int SA_NUM          = 3,
  parameter int SA_OUTPUT_WIDTH = 12,
  parameter int SRAM_ADDR_SIZE  = 10,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic          clk,
  input  logic          resetn,
  wb_arbiter_if.master  bus
);

  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int c_LANE_W  = (SA_NUM > 1) ? $clog2(SA_NUM) : 1;
  localparam int c_ENTRY_W = SRAM_ADDR_SIZE + SA_OUTPUT_WIDTH;

  logic [SA_NUM-1:0]     w_valid;
  logic [SA_NUM-1:0]     w_push;
  logic [SA_NUM-1:0]     w_pop;
  logic [SA_NUM-1:0]     w_drop;
  logic [SA_NUM-1:0]     w_nonempty;
  logic [SA_NUM-1:0]     w_full;
  logic [c_ENTRY_W-1:0]  w_head [SA_NUM];

  logic                  w_load;
  logic                  w_any;
  logic [c_LANE_W-1:0]   w_grant;
  int                    w_idx;

  logic                  r_wen;
  logic [SRAM_ADDR_SIZE-1:0]  r_waddr;
  logic [SA_OUTPUT_WIDTH-1:0] r_wdata;
  logic [SA_NUM-1:0]     r_ovf;
  logic [c_LANE_W-1:0]   r_last;

  // The output register may take a new entry when it is empty or being accepted.
  assign w_load = ~r_wen | bus.sram_ready;

  // --------------------------------------------------------------------------
  // Per-lane FIFOs
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < SA_NUM; i++) begin : g_lane
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    assign w_valid[i]    = |bus.pool_rd_en_out[i];
    assign w_full[i]     = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_nonempty[i] = (r_count != '0);
    assign w_pop[i]      = w_load & w_any & (w_grant == c_LANE_W'(i));
    // A full lane still accepts a push when its head leaves at the same edge.
    assign w_push[i]     = w_valid[i] & (~w_full[i] | w_pop[i]);
    assign w_drop[i]     = w_valid[i] & w_full[i] & ~w_pop[i];
    assign w_head[i]     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
      if (w_push[i]) begin
        r_mem[r_wr_ptr] <= {bus.fifo_wr_addr[i], bus.pool_out[i]};
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[i]) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop[i])  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin grant: scan from the lane after r_last. The scan runs from the
  // farthest lane back to the nearest so the nearest non-empty lane is kept.
  // --------------------------------------------------------------------------
  always_comb begin
    w_any   = 1'b0;
    w_grant = r_last;
    w_idx   = 0;
    for (int k = SA_NUM; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % SA_NUM;
      if (w_nonempty[c_LANE_W'(w_idx)]) begin
        w_any   = 1'b1;
        w_grant = c_LANE_W'(w_idx);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register, last-granted pointer and sticky overflow flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_ovf   <= '0;
      r_last  <= c_LANE_W'(SA_NUM - 1);
    end else begin
      // A drop at the clearing edge survives the clear.
      r_ovf <= (bus.clear_overflow ? '0 : r_ovf) | w_drop;
      if (w_load) begin
        r_wen <= w_any;
        if (w_any) begin
          {r_waddr, r_wdata} <= w_head[w_grant];
          r_last             <= w_grant;
        end
      end
    end
  end

  assign bus.sram_wen   = r_wen;
  assign bus.sram_waddr = r_waddr;
  assign bus.sram_wdata = r_wdata;
  assign bus.lane_full  = w_full;
  assign bus.overflow   = r_ovf;
  assign bus.idle       = ~(|w_nonempty) & ~r_wen;

endmodule
`default_nettype wire
